// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS control unit
// States, opcodes, ALU/mux select codes and the packed control word.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_SE   = 2'b10;
  localparam logic [1:0] SRCB_SE2  = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       branch;
    logic       illegal_op;
  } ctrl_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
  endfunction
endpackage

// File: rtl/control_output_decoder.sv
// control_output_decoder: maps FSM state (plus opcode/zero/mem_ready) to the control word
// Ports: state, opcode, zero, mem_ready in; ctrl (packed ctrl_t) out.
import mips_ctrl_pkg::*;
module control_output_decoder (
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_SE2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !is_legal(opcode);
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SE;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PC_ALUOUT;
        // only beq/bne reach BRANCH, so anything not beq is bne
        ctrl.branch    = (opcode == OP_BEQ) ? zero : !zero;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: main control FSM for the multicycle MIPS datapath
// Ports: clk, reset (async active-low), opcode, zero, mem_ready in;
// datapath enables/selects, PCWrite, zero-qualified Branch, illegal_op, state_o out.
import mips_ctrl_pkg::*;
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                PCWrite,
  output logic                Branch,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_o
);
  state_t state, next;
  ctrl_t  ctrl;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = S_IDLE;
    case (state)
      S_IDLE:      next = S_FETCH;
      S_FETCH:     next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    next = (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                          (opcode == OP_R) ? S_R_EXEC :
                          (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                          (opcode == OP_J) ? S_JUMP :
                          (opcode == OP_ADDI) ? S_ADDI_EXEC : S_FETCH;
      S_MEM_ADDR:  next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    next = S_R_WB;
      S_ADDI_EXEC: next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: next = S_FETCH;
      default:     next = S_IDLE;
    endcase
  end
  control_output_decoder u_dec (
    .state     (state),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );
  assign IorD       = ctrl.iord;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ctrl.alu_op;
  assign PCSource   = ctrl.pc_source;
  assign PCWrite    = ctrl.pc_write;
  assign Branch     = ctrl.branch;
  assign illegal_op = ctrl.illegal_op;
  assign state_o    = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven check of the multicycle control FSM
module tb_multicycle_control_unit;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic PCWrite, Branch, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;
  logic [16:0] obs;
  int asserts = 0, fails = 0;
  localparam logic [16:0] IORD = 17'h10000, MRD = 17'h08000, MWR = 17'h04000, IRW = 17'h02000;
  localparam logic [16:0] RDST = 17'h01000, M2R = 17'h00800, RW = 17'h00400, SA = 17'h00200;
  localparam logic [16:0] SB4 = 17'h00080, SBSE = 17'h00100, SBSE2 = 17'h00180;
  localparam logic [16:0] AOSUB = 17'h00020, AOF = 17'h00040, PCAO = 17'h00008, PCJ = 17'h00010;
  localparam logic [16:0] PCW = 17'h00004, BR = 17'h00002, ILL = 17'h00001;
  localparam logic [16:0] FETCH_OK = MRD | IRW | SB4 | PCW, FETCH_STALL = MRD | SB4;
  localparam logic [16:0] BRANCH_BASE = SA | AOSUB | PCAO;
  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] exp;
  } vec_t;
  vec_t v[$];
  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
    .Branch(Branch), .illegal_op(illegal_op), .state_o(state_o)
  );
  assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSource, PCWrite, Branch, illegal_op};
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask
  task automatic add(input logic [5:0] op, input logic z, input logic rdy, input logic [3:0] st, input logic [16:0] exp);
    v.push_back('{op, z, rdy, st, exp});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    add(6'h23, 0, 1, 4'd0, 17'h0);
    add(6'h23, 0, 1, 4'd1, FETCH_OK);
    add(6'h23, 0, 1, 4'd2, SBSE2);
    add(6'h23, 0, 1, 4'd3, SA | SBSE);
    add(6'h23, 0, 1, 4'd4, MRD | IORD);
    add(6'h23, 0, 1, 4'd5, RW | M2R);
    add(6'h04, 1, 1, 4'd1, FETCH_OK);
    add(6'h04, 1, 1, 4'd2, SBSE2);
    add(6'h04, 1, 1, 4'd9, BRANCH_BASE | BR);
    add(6'h04, 0, 1, 4'd1, FETCH_OK);
    add(6'h04, 0, 1, 4'd2, SBSE2);
    add(6'h04, 0, 1, 4'd9, BRANCH_BASE);
    add(6'h05, 0, 1, 4'd1, FETCH_OK);
    add(6'h05, 0, 1, 4'd2, SBSE2);
    add(6'h05, 0, 1, 4'd9, BRANCH_BASE | BR);
    add(6'h2B, 0, 1, 4'd1, FETCH_OK);
    add(6'h2B, 0, 1, 4'd2, SBSE2);
    add(6'h2B, 0, 1, 4'd3, SA | SBSE);
    add(6'h2B, 0, 0, 4'd6, MWR | IORD);
    add(6'h2B, 0, 0, 4'd6, MWR | IORD);
    add(6'h2B, 0, 0, 4'd6, MWR | IORD);
    add(6'h2B, 0, 1, 4'd6, MWR | IORD);
    add(6'h00, 0, 0, 4'd1, FETCH_STALL);
    add(6'h00, 0, 0, 4'd1, FETCH_STALL);
    add(6'h00, 0, 1, 4'd1, FETCH_OK);
    add(6'h00, 0, 1, 4'd2, SBSE2);
    add(6'h00, 0, 1, 4'd7, SA | AOF);
    add(6'h00, 0, 1, 4'd8, RW | RDST);
    add(6'h08, 0, 1, 4'd1, FETCH_OK);
    add(6'h08, 0, 1, 4'd2, SBSE2);
    add(6'h08, 0, 1, 4'd11, SA | SBSE);
    add(6'h08, 0, 1, 4'd12, RW);
    add(6'h02, 0, 1, 4'd1, FETCH_OK);
    add(6'h02, 0, 1, 4'd2, SBSE2);
    add(6'h02, 0, 1, 4'd10, PCW | PCJ);
    add(6'h3F, 0, 1, 4'd1, FETCH_OK);
    add(6'h3F, 0, 1, 4'd2, SBSE2 | ILL);
    add(6'h3F, 0, 1, 4'd1, FETCH_OK);
    add(6'h05, 1, 1, 4'd2, SBSE2);
    add(6'h05, 1, 1, 4'd9, BRANCH_BASE);
    add(6'h05, 1, 1, 4'd1, FETCH_OK);
    #1;
    chk("reset_state", 0, state_o, 4'd0);
    chk("reset_outputs", 0, obs, 17'h0);
    @(negedge clk);
    chk("reset_hold_outputs", 1, obs, 17'h0);
    reset = 1'b1;
    foreach (v[i]) begin
      opcode = v[i].op;
      zero = v[i].z;
      mem_ready = v[i].rdy;
      #1;
      chk("state", i, state_o, v[i].st);
      chk("ctrl", i, obs, v[i].exp);
      chk("pcw_branch_excl", i, PCWrite & Branch, 1'b0);
      @(negedge clk);
    end
    // abort a lw while it is stalled in MEM_READ
    opcode = 6'h23;
    mem_ready = 1'b1;
    begin
      int n = 0;
      #1;
      while (state_o != 4'd4 && n < 12) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("reach_mem_read", n, state_o, 4'd4);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("mem_read_stall_state", 0, state_o, 4'd4);
    chk("mem_read_stall_ctrl", 0, obs, MRD | IORD);
    #1 reset = 1'b0;
    #1;
    chk("abort_state", 0, state_o, 4'd0);
    chk("abort_outputs", 0, obs, 17'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_hold_state", 1, state_o, 4'd0);
    chk("abort_hold_outputs", 1, obs, 17'h0);
    reset = 1'b1;
    chk("restart_idle", 0, state_o, 4'd0);
    chk("restart_idle_pcw", 0, PCWrite, 1'b0);
    @(negedge clk);
    #1;
    chk("restart_fetch", 1, state_o, 4'd1);
    chk("restart_fetch_pcw", 1, PCWrite, 1'b1);
    @(negedge clk);
    #1;
    chk("restart_decode", 2, state_o, 4'd2);
    chk("restart_decode_pcw", 2, PCWrite, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
